// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader.
//   BYTE_SIZE        : width of one stream byte
//   INSTRUCTION_HALT : word value that ends a load session
//   loader_state_t   : loader FSM state encoding
package instruction_loader_pkg;

  localparam int BYTE_SIZE = 8;
  localparam logic [31:0] INSTRUCTION_HALT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RECEIVE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5,
    ST_CHECK   = 3'd6
  } loader_state_t;

endpackage

// File: rtl/instruction_loader_byte_to_word_packer.sv
// Byte-to-word packer: shifts accepted bytes in MSB-first so the first byte
// of a word ends up in the top byte lane (big-endian).
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   clear           : synchronous restart of the byte index
//   byte_accept     : a byte is transferred this cycle
//   data_byte       : the byte being transferred
//   word            : assembly register (holds last complete word until the
//                     next word starts shifting in)
//   word_complete   : the accepted byte is the last byte of a word
module byte_to_word_packer
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  byte_accept,
  input  logic [BYTE_SIZE-1:0]                  data_byte,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] word,
  output logic                                  word_complete
);

  localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int IDX_W  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE_IN_BYTES - 1);

  logic [IDX_W-1:0] byte_index;

  assign word_complete = byte_accept && (byte_index == LAST_IDX);

  // Only the index is restarted on clear: a full word always overwrites
  // every byte lane, so stale partial data can never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_index <= '0;
      word       <= '0;
    end else if (clear) begin
      byte_index <= '0;
    end else if (byte_accept) begin
      word       <= (word << BYTE_SIZE) | WORD_W'(data_byte);
      byte_index <= word_complete ? '0 : byte_index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: writer side of instruction_memory's sequential load
// port. Assembles a byte stream into words, writes each word once in order,
// and stops after HALT (done) or when memory fills without HALT (error).
// Optional: INSTRUCTION_LOADER_CHECKSUM_EN adds an XOR checksum byte after
// HALT and the o_checksum_error output.
// Ports:
//   i_clk, i_reset        : clock, async active-low reset
//   i_start               : pulse, begins (or restarts) a load session
//   i_byte_valid, i_byte  : incoming byte stream
//   o_byte_ready          : loader accepts a byte this cycle
//   o_clear               : clear strobe to instruction_memory
//   o_instruction_write   : write strobe to instruction_memory
//   o_instruction         : assembled instruction word
//   o_word_count          : words written in this session
//   o_done / o_error      : session result flags
//   o_checksum_error      : checksum mismatch (checksum build only)
//
// state   | meaning
// IDLE    | waiting for i_start
// CLEAR   | one-cycle memory clear, counters restart
// RECEIVE | accepting bytes of the current word
// WRITE   | one-cycle write strobe of the assembled word
// CHECK   | accepting the checksum byte after HALT (checksum build)
// DONE    | HALT written (and checksum matched)
// ERROR   | memory full without HALT, or checksum mismatch
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 10,
  parameter int COUNT_SIZE         = $clog2(MEM_SIZE_IN_WORDS + 1)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic                                  i_byte_valid,
  input  logic [BYTE_SIZE-1:0]                  i_byte,
  output logic                                  o_byte_ready,
  output logic                                  o_clear,
  output logic                                  o_instruction_write,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] o_instruction,
  output logic [COUNT_SIZE-1:0]                 o_word_count,
  output logic                                  o_done,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  output logic                                  o_checksum_error,
`endif
  output logic                                  o_error
);

  localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam logic [COUNT_SIZE-1:0] MEM_FULL = COUNT_SIZE'(MEM_SIZE_IN_WORDS);
  localparam logic [WORD_W-1:0] HALT_WORD = WORD_W'(INSTRUCTION_HALT);

  loader_state_t state, state_next;

  logic                  recv_accept;
  logic                  word_complete;
  logic [COUNT_SIZE-1:0] count_inc;
  logic                  is_halt;

  assign recv_accept = i_byte_valid && (state == ST_RECEIVE);
  assign count_inc   = o_word_count + COUNT_SIZE'(1);
  assign is_halt     = (o_instruction == HALT_WORD);

  byte_to_word_packer #(
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
  ) u_packer (
    .clk          (i_clk),
    .rst_n        (i_reset),
    .clear        (state == ST_CLEAR),
    .byte_accept  (recv_accept),
    .data_byte    (i_byte),
    .word         (o_instruction),
    .word_complete(word_complete)
  );

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [BYTE_SIZE-1:0] checksum;
  logic                 check_accept;
  logic                 check_match;

  assign check_accept = i_byte_valid && (state == ST_CHECK);
  assign check_match  = (i_byte == checksum);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      checksum         <= '0;
      o_checksum_error <= 1'b0;
    end else if (state == ST_CLEAR) begin
      checksum         <= '0;
      o_checksum_error <= 1'b0;
    end else begin
      if (recv_accept) begin
        checksum <= checksum ^ i_byte;
      end
      if (check_accept && !i_start && !check_match) begin
        o_checksum_error <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      o_word_count <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) begin
        o_word_count <= '0;
      end else if (state == ST_WRITE) begin
        o_word_count <= count_inc;
      end
    end
  end

  always_comb begin
    state_next          = state;
    o_byte_ready        = 1'b0;
    o_clear             = 1'b0;
    o_instruction_write = 1'b0;
    o_done              = 1'b0;
    o_error             = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        o_clear    = 1'b1;
        state_next = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        o_byte_ready = 1'b1;
        if (i_start) begin
          state_next = ST_CLEAR;
        end else if (word_complete) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The strobe completes even if i_start aborts the session here.
        o_instruction_write = 1'b1;
        if (i_start) begin
          state_next = ST_CLEAR;
        end else if (is_halt) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          state_next = ST_CHECK;
`else
          state_next = ST_DONE;
`endif
        end else if (count_inc == MEM_FULL) begin
          state_next = ST_ERROR;
        end else begin
          state_next = ST_RECEIVE;
        end
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        o_byte_ready = 1'b1;
        if (i_start) begin
          state_next = ST_CLEAR;
        end else if (check_accept) begin
          state_next = check_match ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) state_next = ST_CLEAR;
      end
      ST_ERROR: begin
        o_error = 1'b1;
        if (i_start) state_next = ST_CLEAR;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader. Expected written words are
// queued as stimulus is driven and popped when the write strobe is seen.
// Build with INSTRUCTION_LOADER_CHECKSUM_EN to also exercise the checksum.
module tb_instruction_loader;

  localparam int CNT_W = $clog2(10 + 1);

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_start;
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              o_clear;
  logic              o_instruction_write;
  logic [31:0]       o_instruction;
  logic [CNT_W-1:0]  o_word_count;
  logic              o_done;
  logic              o_error;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic              o_checksum_error;
`endif

  instruction_loader dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_start            (i_start),
    .i_byte_valid       (i_byte_valid),
    .i_byte             (i_byte),
    .o_byte_ready       (o_byte_ready),
    .o_clear            (o_clear),
    .o_instruction_write(o_instruction_write),
    .o_instruction      (o_instruction),
    .o_word_count       (o_word_count),
    .o_done             (o_done),
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    .o_checksum_error   (o_checksum_error),
`endif
    .o_error            (o_error)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int write_cnt = 0;
  int clear_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Strobe monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (i_reset === 1'b1) begin
      if (o_clear) clear_cnt++;
      if (o_clear && o_instruction_write) chk("clear_write_overlap", 32'd1, 32'd0);
      if (o_instruction_write) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", o_instruction, 32'hxxxx_xxxx);
        end else begin
          chk("write_data", o_instruction, exp_q.pop_front());
        end
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte_valid = 1'b1;
    i_byte       = b;
    while (!o_byte_ready && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 40) chk("byte_timeout", 32'd1, 32'd0);
    @(negedge i_clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit push);
    if (push) exp_q.push_back(w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("clear_strobe", {31'd0, o_clear}, 32'd1);
    chk("clear_flags", {30'd0, o_done, o_error}, 32'd0);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(o_done || o_error) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("end_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int wr0, cl0;

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_byte_valid = 1'b0; i_byte = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_instr", o_instruction, 32'd0);
    chk("rst_flags", {27'd0, o_byte_ready, o_clear, o_instruction_write, o_done, o_error}, 32'd0);
    chk("rst_count", 32'(o_word_count), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);

    // 1: two words ending in HALT
    cl0 = clear_cnt; wr0 = write_cnt;
    pulse_start();
    send_word(32'h1234_5678, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b1);
    wait_end();
    chk("t1_clear_cycles", 32'(clear_cnt - cl0), 32'd1);
    chk("t1_writes", 32'(write_cnt - wr0), 32'd2);
    chk("t1_count", 32'(o_word_count), 32'd2);
    chk("t1_done_err", {30'd0, o_done, o_error}, 32'b10);

    // 2: memory fills without HALT
    wr0 = write_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(32'hA000_0000 + 32'(i * 32'h0101_0101), 1'b1);
    wait_end();
    chk("t2_writes", 32'(write_cnt - wr0), 32'd10);
    chk("t2_count", 32'(o_word_count), 32'd10);
    chk("t2_done_err", {30'd0, o_done, o_error}, 32'b01);
    i_byte_valid = 1'b1; i_byte = 8'h55;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("t2_ready_full", {31'd0, o_byte_ready}, 32'd0);
    end
    i_byte_valid = 1'b0;
    chk("t2_no_extra_write", 32'(write_cnt - wr0), 32'd10);

    // 3: HALT as the last word that fits
    wr0 = write_cnt;
    pulse_start();
    for (int i = 0; i < 9; i++) send_word(32'h0000_1000 + 32'(i), 1'b1);
    send_word(32'hFFFF_FFFF, 1'b1);
    wait_end();
    chk("t3_writes", 32'(write_cnt - wr0), 32'd10);
    chk("t3_count", 32'(o_word_count), 32'd10);
    chk("t3_done_err", {30'd0, o_done, o_error}, 32'b10);

    // 4: abort mid-word, restart with HALT
    wr0 = write_cnt; cl0 = clear_cnt;
    pulse_start();
    send_byte(8'hDE);
    send_byte(8'hAD);
    pulse_start();
    send_word(32'hFFFF_FFFF, 1'b1);
    wait_end();
    chk("t4_clears", 32'(clear_cnt - cl0), 32'd2);
    chk("t4_writes", 32'(write_cnt - wr0), 32'd1);
    chk("t4_count", 32'(o_word_count), 32'd1);
    chk("t4_done", {31'd0, o_done}, 32'd1);

    // 5: reset mid-word
    wr0 = write_cnt;
    pulse_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    i_reset = 1'b0;
    #1;
    chk("t5_instr", o_instruction, 32'd0);
    chk("t5_flags", {27'd0, o_byte_ready, o_clear, o_instruction_write, o_done, o_error}, 32'd0);
    chk("t5_count", 32'(o_word_count), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    i_byte_valid = 1'b1; i_byte = 8'h44;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      chk("t5_idle_ready", {31'd0, o_byte_ready}, 32'd0);
    end
    i_byte_valid = 1'b0;
    chk("t5_no_write", 32'(write_cnt - wr0), 32'd0);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    // 6: checksum good, then bad
    pulse_start();
    send_word(32'h0102_0304, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b1);
    send_byte(8'h04);
    wait_end();
    chk("t6_good", {29'd0, o_done, o_error, o_checksum_error}, 32'b100);
    pulse_start();
    send_word(32'h0102_0304, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b1);
    send_byte(8'h00);
    wait_end();
    chk("t6_bad", {29'd0, o_done, o_error, o_checksum_error}, 32'b011);
`endif

    repeat (2) @(negedge i_clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
